// File: rtl/multicycle_sequencer_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath/memory.
// The sequencer takes the master side; the datapath (or a bench) takes the slave side.
interface multicycle_sequencer_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             mem_ready;
    logic             mem_req;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic [1:0]       mem_size;
    logic             ir_write;
    logic             pc_write;
    logic             branch;
    logic [1:0]       pc_src;
    logic             reg_read;
    logic             reg_write;
    logic [1:0]       reg_dst;
    logic             alu_src;
    logic [1:0]       mem_to_reg;
    logic             instr_retired;
    logic [CNT_W-1:0] retired_count;
    logic             fault;

    modport master (
        input  opcode, funct, mem_ready,
        output mem_req, i_or_d, mem_read, mem_write, mem_size, ir_write, pc_write,
               branch, pc_src, reg_read, reg_write, reg_dst, alu_src, mem_to_reg,
               instr_retired, retired_count, fault
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  mem_req, i_or_d, mem_read, mem_write, mem_size, ir_write, pc_write,
               branch, pc_src, reg_read, reg_write, reg_dst, alu_src, mem_to_reg,
               instr_retired, retired_count, fault
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with memory handshake,
// retired-instruction counter and a sticky fault on illegal opcode or memory timeout.
module multicycle_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_sequencer_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [2:0]       state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] retired_count;
    logic             retire;

    logic is_rtype, is_jr, is_imm, is_lw, is_store, is_legal;

    always_comb begin
        is_rtype = (bus.opcode == 6'h00);
        is_jr    = is_rtype && (bus.funct == 6'h08);
        is_imm   = (bus.opcode[5:3] == 3'b001);
        is_lw    = (bus.opcode == 6'h23);
        is_store = (bus.opcode == 6'h28) || (bus.opcode == 6'h29) || (bus.opcode == 6'h2B);
        is_legal = is_rtype || is_imm || is_lw || is_store ||
                   (bus.opcode == 6'h02) || (bus.opcode == 6'h03) ||
                   (bus.opcode == 6'h04) || (bus.opcode == 6'h05);
    end

    // Last permitted wait cycle: a miss here means the next state is FAULT.
    logic timed_out;
    assign timed_out = (wait_cnt == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt      = state;
        retire         = 1'b0;
        bus.mem_req    = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_size   = 2'b00;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.branch     = 1'b0;
        bus.pc_src     = 2'b00;
        bus.reg_read   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 2'b00;
        bus.alu_src    = 1'b0;
        bus.mem_to_reg = 2'b00;
        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                bus.mem_req  = 1'b1;
                bus.mem_read = 1'b1;
                bus.mem_size = 2'b10;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_nxt    = S_DECODE;
                end else if (timed_out) begin
                    state_nxt = S_FAULT;
                end
            end
            S_DECODE: begin
                bus.reg_read = 1'b1;
                if (!is_legal) begin
                    state_nxt = S_FAULT;
                end else if (bus.opcode == 6'h02 || bus.opcode == 6'h03) begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = 2'b10;
                    retire       = 1'b1;
                    state_nxt    = S_FETCH;
                    if (bus.opcode == 6'h03) begin
                        bus.reg_write  = 1'b1;
                        bus.reg_dst    = 2'b10;
                        bus.mem_to_reg = 2'b10;
                    end
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                bus.reg_read = 1'b1;
                bus.alu_src  = is_imm || is_lw || is_store;
                if (bus.opcode == 6'h04 || bus.opcode == 6'h05) begin
                    bus.branch = 1'b1;
                    bus.pc_src = 2'b01;
                    retire     = 1'b1;
                    state_nxt  = S_FETCH;
                end else if (is_jr) begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = 2'b11;
                    retire       = 1'b1;
                    state_nxt    = S_FETCH;
                end else if (is_lw || is_store) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                bus.mem_req   = 1'b1;
                bus.i_or_d    = 1'b1;
                bus.alu_src   = 1'b1;
                bus.mem_read  = is_lw;
                bus.mem_write = !is_lw;
                case (bus.opcode)
                    6'h28:   bus.mem_size = 2'b00;
                    6'h29:   bus.mem_size = 2'b01;
                    default: bus.mem_size = 2'b10;
                endcase
                if (bus.mem_ready) begin
                    retire    = !is_lw;
                    state_nxt = is_lw ? S_WB : S_FETCH;
                end else if (timed_out) begin
                    state_nxt = S_FAULT;
                end
            end
            S_WB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = is_rtype ? 2'b01 : 2'b00;
                bus.mem_to_reg = is_lw ? 2'b01 : 2'b00;
                retire         = 1'b1;
                state_nxt      = S_FETCH;
            end
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_FAULT;
        endcase
    end

    assign bus.instr_retired = retire;
    assign bus.retired_count = retired_count;
    assign bus.fault         = (state == S_FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            wait_cnt      <= '0;
            retired_count <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                wait_cnt <= '0;
            else if ((state == S_FETCH || state == S_MEM) && !bus.mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
            if (retire)
                retired_count <= retired_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: the stimulus walks each instruction through its expected phases,
// queues the per-cycle outputs the rules imply, and a negedge monitor compares them.
module tb_multicycle_sequencer;
    localparam int CW      = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_sequencer_if #(.CNT_W(CW)) bus ();
    multicycle_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef enum int {P_IDLE, P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_FAULT} phase_t;

    typedef struct packed {
        logic          mem_req, i_or_d, mem_read, mem_write;
        logic [1:0]    mem_size;
        logic          ir_write, pc_write, branch;
        logic [1:0]    pc_src;
        logic          reg_read, reg_write;
        logic [1:0]    reg_dst;
        logic          alu_src;
        logic [1:0]    mem_to_reg;
        logic          instr_retired, fault;
        logic [CW-1:0] cnt;
    } outs_t;

    typedef struct {
        outs_t  o;
        phase_t ph;
    } exp_t;

    exp_t          q[$];
    int            checks = 0;
    int            failures = 0;
    int            cyc_n = 0;
    logic [CW-1:0] model_cnt = '0;

    logic [5:0] legal_ops [17] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                                   6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h28, 6'h29, 6'h2B};

    function automatic bit legal(input logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_store(input logic [5:0] op);
        return op == 6'h28 || op == 6'h29 || op == 6'h2B;
    endfunction

    // Expected outputs for one cycle, straight from the per-phase strobe table.
    function automatic outs_t ref_outs(input phase_t ph, input logic [5:0] op,
                                       input logic [5:0] fn, input logic rdy);
        outs_t o = '0;
        o.cnt = model_cnt;
        case (ph)
            P_FETCH: begin
                o.mem_req = 1; o.mem_read = 1; o.mem_size = 2'b10;
                if (rdy) begin o.ir_write = 1; o.pc_write = 1; end
            end
            P_DECODE: begin
                o.reg_read = 1;
                if (op == 6'h02 || op == 6'h03) begin
                    o.pc_write = 1; o.pc_src = 2'b10; o.instr_retired = 1;
                end
                if (op == 6'h03) begin
                    o.reg_write = 1; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10;
                end
            end
            P_EXEC: begin
                o.reg_read = 1;
                o.alu_src  = (op >= 6'h08 && op <= 6'h0F) || op == 6'h23 || is_store(op);
                if (op == 6'h04 || op == 6'h05) begin
                    o.branch = 1; o.pc_src = 2'b01; o.instr_retired = 1;
                end
                if (op == 6'h00 && fn == 6'h08) begin
                    o.pc_write = 1; o.pc_src = 2'b11; o.instr_retired = 1;
                end
            end
            P_MEM: begin
                o.mem_req = 1; o.i_or_d = 1; o.alu_src = 1;
                o.mem_size = (op == 6'h28) ? 2'b00 : (op == 6'h29) ? 2'b01 : 2'b10;
                if (op == 6'h23) o.mem_read = 1;
                else o.mem_write = 1;
                if (is_store(op) && rdy) o.instr_retired = 1;
            end
            P_WB: begin
                o.reg_write = 1; o.instr_retired = 1;
                o.reg_dst    = (op == 6'h00) ? 2'b01 : 2'b00;
                o.mem_to_reg = (op == 6'h23) ? 2'b01 : 2'b00;
            end
            P_FAULT: o.fault = 1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.mem_req = bus.mem_req;     o.i_or_d = bus.i_or_d;
        o.mem_read = bus.mem_read;   o.mem_write = bus.mem_write;
        o.mem_size = bus.mem_size;   o.ir_write = bus.ir_write;
        o.pc_write = bus.pc_write;   o.branch = bus.branch;
        o.pc_src = bus.pc_src;       o.reg_read = bus.reg_read;
        o.reg_write = bus.reg_write; o.reg_dst = bus.reg_dst;
        o.alu_src = bus.alu_src;     o.mem_to_reg = bus.mem_to_reg;
        o.instr_retired = bus.instr_retired;
        o.fault = bus.fault;         o.cnt = bus.retired_count;
        return o;
    endfunction

    always @(negedge clk) begin
        cyc_n <= cyc_n + 1;
        if (q.size() > 0) begin
            exp_t  e;
            outs_t got;
            e   = q.pop_front();
            got = sample();
            checks++;
            if (got !== e.o) begin
                failures++;
                $display("FAIL %s cycle=%0d got=%h want=%h", e.ph.name(), cyc_n, got, e.o);
            end
        end
    end

    // One clock: present inputs, queue the expected outputs, advance.
    task automatic cyc(input phase_t ph, input logic [5:0] op, input logic [5:0] fn,
                       input logic rdy);
        exp_t e;
        bus.opcode = op; bus.funct = fn; bus.mem_ready = rdy;
        e.o  = ref_outs(ph, op, fn, rdy);
        e.ph = ph;
        q.push_back(e);
        @(posedge clk); #1;
        if (e.o.instr_retired) model_cnt = model_cnt + 1'b1;
    endtask

    task automatic rnd_cyc(input phase_t ph);
        cyc(ph, 6'($urandom), 6'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_cnt = '0;
        rnd_cyc(P_IDLE);
        rnd_cyc(P_IDLE);
        rst_n = 1'b1;
        rnd_cyc(P_IDLE);
    endtask

    // fw/mw: miss cycles before mem_ready in FETCH/MEM; abort_mem >= 0 stops inside MEM.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                             input int mw, input int abort_mem, output bit faulted);
        faulted = 0;
        for (int i = 0; ; i++) begin
            if (i == TIMEOUT) begin faulted = 1; return; end
            if (i < fw) cyc(P_FETCH, 6'($urandom), 6'($urandom), 1'b0);
            else begin cyc(P_FETCH, 6'($urandom), 6'($urandom), 1'b1); break; end
        end
        cyc(P_DECODE, op, fn, 1'($urandom));
        if (!legal(op)) begin faulted = 1; return; end
        if (op == 6'h02 || op == 6'h03) return;
        cyc(P_EXEC, op, fn, 1'($urandom));
        if (op == 6'h04 || op == 6'h05 || (op == 6'h00 && fn == 6'h08)) return;
        if (op == 6'h23 || is_store(op)) begin
            for (int i = 0; ; i++) begin
                if (i == abort_mem) return;
                if (i == TIMEOUT) begin faulted = 1; return; end
                if (i < mw) cyc(P_MEM, op, fn, 1'b0);
                else begin cyc(P_MEM, op, fn, 1'b1); break; end
            end
            if (is_store(op)) return;
        end
        cyc(P_WB, op, fn, 1'($urandom));
    endtask

    task automatic fault_then_reset();
        repeat (4) rnd_cyc(P_FAULT);
        do_reset();
    endtask

    initial begin
        bit         f;
        logic [5:0] op, fn;
        bus.opcode = '0; bus.funct = '0; bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        do_reset();
        run_instr(6'h00, 6'h20, 0, 0, -1, f);   // add
        run_instr(6'h23, 6'h00, 0, 3, -1, f);   // lw with 3 miss cycles
        run_instr(6'h04, 6'h00, 0, 0, -1, f);   // beq
        run_instr(6'h2B, 6'h00, 1, 0, -1, f);   // sw
        run_instr(6'h03, 6'h00, 0, 0, -1, f);   // jal
        run_instr(6'h00, 6'h08, 0, 0, -1, f);   // jr
        run_instr(6'h28, 6'h00, 0, 1, -1, f);   // sb
        run_instr(6'h29, 6'h00, 0, 0, -1, f);   // sh
        run_instr(6'h0F, 6'h00, 15, 0, -1, f);  // lui, ready on last allowed fetch cycle
        run_instr(6'h23, 6'h00, 0, 15, -1, f);  // lw, ready on last allowed mem cycle
        for (int n = 0; n < 60; n++) begin
            op = legal_ops[$urandom_range(0, 16)];
            fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
            run_instr(op, fn, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0, -1, f);
            if (f) fault_then_reset();
        end
        run_instr(6'h23, 6'h00, 0, 5, 2, f);    // reset lands inside MEM
        do_reset();
        run_instr(6'h00, 6'h21, 0, 0, -1, f);
        run_instr(6'h3F, 6'h00, 0, 0, -1, f);   // illegal opcode
        if (f) fault_then_reset();
        run_instr(6'h01, 6'h00, 0, 0, -1, f);   // illegal opcode
        if (f) fault_then_reset();
        run_instr(6'h00, 6'h20, 16, 0, -1, f);  // fetch timeout
        if (f) fault_then_reset();
        run_instr(6'h2B, 6'h00, 0, 16, -1, f);  // mem timeout
        if (f) fault_then_reset();
        run_instr(6'h09, 6'h00, 0, 0, -1, f);
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle=%0d", cyc_n);
        $fatal(1, "watchdog");
    end
endmodule
